// File: rtl/fetch_stage_if.sv
// fetch_stage_if: IF-stage control, instruction-RAM and IF/ID signals.
// FETCH_PERF_CNT_EN adds the perf_fetched/perf_stalls counter outputs.
interface fetch_stage_if #(parameter int IMEM_AW = 9);
    logic               stall;
    logic               flush;
    logic [31:0]        branch_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic [31:0]        ifid_instr;
    logic [31:0]        ifid_pc4;
    logic               ifid_valid;
    logic [31:0]        pc;
    logic               fetch_halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]        perf_fetched;
    logic [31:0]        perf_stalls;
    modport master(input stall, flush, branch_target, imem_data,
                   output imem_addr, ifid_instr, ifid_pc4, ifid_valid, pc, fetch_halted,
                   perf_fetched, perf_stalls);
    modport slave(output stall, flush, branch_target, imem_data,
                  input imem_addr, ifid_instr, ifid_pc4, ifid_valid, pc, fetch_halted,
                  perf_fetched, perf_stalls);
`else
    modport master(input stall, flush, branch_target, imem_data,
                   output imem_addr, ifid_instr, ifid_pc4, ifid_valid, pc, fetch_halted);
    modport slave(output stall, flush, branch_target, imem_data,
                  input imem_addr, ifid_instr, ifid_pc4, ifid_valid, pc, fetch_halted);
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC, IF/ID register, stall/flush and halt-word stop.
// Optional FETCH_PERF_CNT_EN adds fetched-instruction and stall-cycle counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 9,
    parameter logic [31:0] HALT_WORD = 32'hffff_ffff
) (
    input logic clk,
    input logic reset,
    fetch_stage_if.master f
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d;
    logic        valid_q, valid_d, load;
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        load    = 1'b0;
        if (f.flush) begin
            pc_d    = {f.branch_target[31:2], 2'b00};
            instr_d = '0;
            valid_d = 1'b0;
            state_d = RUN;
        end else if (!f.stall) begin
            if (state_q == RUN) begin
                instr_d = f.imem_data;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                load    = 1'b1;
                // The halt word itself retires; the PC parks on it.
                state_d = (f.imem_data == HALT_WORD) ? HALTED : RUN;
                pc_d    = (f.imem_data == HALT_WORD) ? pc_q : pc_plus4;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
    end
    assign f.imem_addr    = pc_q[IMEM_AW+1:2];
    assign f.ifid_instr   = instr_q;
    assign f.ifid_pc4     = pc4_q;
    assign f.ifid_valid   = valid_q;
    assign f.pc           = pc_q;
    assign f.fetch_halted = (state_q == HALTED);
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_q, stalls_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_q + {31'd0, load};
            stalls_q  <= stalls_q + {31'd0, f.stall & ~f.flush};
        end
    end
    assign f.perf_fetched = fetched_q;
    assign f.perf_stalls  = stalls_q;
`else
    logic unused;
    assign unused = load;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors into a scoreboard queue, checked by a separate monitor.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    fetch_stage_if #(.IMEM_AW(9)) bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .f(bus));
    always #5 clk = ~clk;

    logic [31:0] ram [0:511];
    assign bus.imem_data = ram[bus.imem_addr];

    typedef struct {
        int          id;
        logic [31:0] instr, pc4, pc;
        logic        valid, halted;
    } exp_t;
    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int vid = 0;

    localparam logic [31:0] A = 32'h2001_0001, B = 32'h2002_0002, C = 32'h2003_0003;
    localparam logic [31:0] E = 32'h2008_0008, F = 32'h2009_0009;
    localparam logic [31:0] G = 32'h2010_0010, H = 32'h2011_0011, W = 32'h21ff_01ff;
    localparam logic [31:0] HW = 32'hffff_ffff;

    task automatic step(input logic r, input logic s, input logic fl, input logic [31:0] bt,
                        input logic [31:0] ei, input logic [31:0] ep4, input logic ev,
                        input logic [31:0] epc, input logic eh);
        exp_t e;
        @(negedge clk);
        reset = r;
        bus.stall = s;
        bus.flush = fl;
        bus.branch_target = bt;
        vid++;
        e.id = vid; e.instr = ei; e.pc4 = ep4; e.valid = ev; e.pc = epc; e.halted = eh;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (bus.ifid_instr !== e.instr || bus.ifid_pc4 !== e.pc4 || bus.ifid_valid !== e.valid ||
                    bus.pc !== e.pc || bus.fetch_halted !== e.halted) begin
                    miscompares++;
                    $display("FAIL vec%0d: got instr=%h pc4=%h valid=%b pc=%h halted=%b; want instr=%h pc4=%h valid=%b pc=%h halted=%b",
                             e.id, bus.ifid_instr, bus.ifid_pc4, bus.ifid_valid, bus.pc, bus.fetch_halted,
                             e.instr, e.pc4, e.valid, e.pc, e.halted);
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    task automatic perf_check(input string nm, input logic [31:0] ef, input logic [31:0] es);
        @(posedge clk);
        #2;
        vectors++;
        if (bus.perf_fetched !== ef || bus.perf_stalls !== es) begin
            miscompares++;
            $display("FAIL %s: got fetched=%0d stalls=%0d; want fetched=%0d stalls=%0d",
                     nm, bus.perf_fetched, bus.perf_stalls, ef, es);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'h0000_0000;
        ram[0] = A; ram[1] = B; ram[2] = C; ram[3] = HW;
        ram[8] = E; ram[9] = F; ram[16] = G; ram[17] = H; ram[18] = HW; ram[511] = W;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.branch_target = '0;
        //   rst  stl  fl   target         instr  pc4            v     pc             halted
        step(1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 32'h0,       1'b0, 32'h0,        1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        A,     32'h4,       1'b1, 32'h4,        1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        B,     32'h8,       1'b1, 32'h8,        1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,        B,     32'h8,       1'b1, 32'h8,        1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0,        B,     32'h8,       1'b1, 32'h8,        1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        C,     32'hc,       1'b1, 32'hc,        1'b0);
`ifdef FETCH_PERF_CNT_EN
        perf_check("perf_after_stall", 32'd3, 32'd2);
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0,        HW,    32'h10,      1'b1, 32'hc,        1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h20,       32'h0, 32'h10,      1'b0, 32'h20,       1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        E,     32'h24,      1'b1, 32'h24,       1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        F,     32'h28,      1'b1, 32'h28,       1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h43,       32'h0, 32'h28,      1'b0, 32'h40,       1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        G,     32'h44,      1'b1, 32'h44,       1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        H,     32'h48,      1'b1, 32'h48,       1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        HW,    32'h4c,      1'b1, 32'h48,       1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 32'h4c,      1'b0, 32'h48,       1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 32'h4c,      1'b0, 32'h48,       1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0,        32'h0, 32'h4c,      1'b0, 32'h48,       1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0,        32'h0, 32'h0,       1'b0, 32'h0,        1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        A,     32'h4,       1'b1, 32'h4,        1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hffff_fffe, 32'h0, 32'h4,      1'b0, 32'hffff_fffc, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        W,     32'h0,       1'b1, 32'h0,        1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0,        A,     32'h4,       1'b1, 32'h4,        1'b0);
`ifdef FETCH_PERF_CNT_EN
        perf_check("perf_after_reset", 32'd3, 32'd0);
`else
        @(posedge clk);
`endif
        repeat (3) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked vectors; want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
